fifo_byte_serializer: RTL
=========================

Name: fifo_byte_serializer

Overview:
- Consumer stage directly downstream of the 32-bit synchronous FIFO (8-deep, registered read data, ren/empty interface).
- Pops 32-bit words from the FIFO and emits them as 8-bit bytes on a valid/ready stream toward a byte-wide sink (UART/SPI TX, byte bus).
- Handles the FIFO's 1-cycle read latency.
- Flags the last byte of each word and counts words fully sent.

Parameters:
- MSB_FIRST, 1, 1: byte order [31:24],[23:16],[15:8],[7:0]; 0: order [7:0] first through [31:24] last.
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  32  FIFO data_out; valid the cycle after a pop.
- fifo_ren  out  1  FIFO read enable (pop request).
- m_valid  out  1  byte available on m_data.
- m_ready  in  1  sink accepts byte when m_valid && m_ready.
- m_data  out  8  current byte.
- m_last  out  1  high with the 4th byte of a word.
- busy  out  1  high whenever state != IDLE.
- word_count  out  CNT_W  number of words whose 4th byte was accepted.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, shift register=0, byte_idx=0, m_valid=0, m_data=0, m_last=0, word_count=0.
  - fifo_ren=0 while rst=1.
  - Reset overrides all other activity. A word mid-serialization is discarded, not re-read.
- States: IDLE, FETCH, SEND.
- IDLE:
  - fifo_ren = !fifo_empty.
  - If !fifo_empty, go to FETCH; otherwise stay in IDLE.
- FETCH (one cycle):
  - fifo_rdata is valid this cycle.
  - Latch fifo_rdata into the 32-bit word register, set byte_idx=0, go to SEND.
  - fifo_ren=0.
- SEND:
  - m_valid=1.
  - m_data is the byte of the word register selected by byte_idx and MSB_FIRST.
  - m_last = (byte_idx==3).
  - Handshake = m_valid && m_ready.
  - On handshake with byte_idx<3: byte_idx increments, next byte shown the following cycle.
  - On handshake with byte_idx==3:
    - word_count increments, wrapping modulo 2^CNT_W.
    - If !fifo_empty in that same cycle: fifo_ren=1 and go to FETCH (back-to-back words).
    - Otherwise go to IDLE.
  - No handshake: m_data and m_last hold stable, byte_idx holds, m_valid stays 1. A valid byte is never withdrawn.
- fifo_ren is combinational:
  - fifo_ren = (IDLE && !fifo_empty) || (SEND && m_ready && byte_idx==3 && !fifo_empty).
  - Never asserted when fifo_empty=1.
  - At most one pop per word.
- m_valid, m_data and m_last are registered or decoded from registered state only. There is no combinational path from m_ready to m_valid/m_data.
- Latency, FIFO non-empty in IDLE to first byte valid: 2 cycles (IDLE pop, FETCH, SEND).
- Throughput with m_ready held at 1: 5 cycles per word (4 bytes plus 1 FETCH bubble).
- busy = (state != IDLE).
- If the FIFO becomes non-empty during SEND, it is not popped until the 4th-byte handshake.

Test Plan:
- Reset, then FIFO loaded with 0xA1B2C3D4, m_ready=1, MSB_FIRST=1:
  - fifo_ren pulses once.
  - m_data sequence is A1,B2,C3,D4 on consecutive cycles, with m_last only on D4.
  - word_count=1, then IDLE with busy=0.
- Same word with MSB_FIRST=0:
  - byte order D4,C3,B2,A1, with m_last on A1.
- Backpressure: m_ready=0 for 3 cycles during byte 1 of 0x11223344:
  - m_valid stays 1 and m_data holds 0x22 throughout.
  - Sequence completes as 11,22,33,44 with no duplicate and no drop.
- Back-to-back: FIFO holds 0x01020304 and 0x05060708, m_ready=1:
  - second fifo_ren fires in the same cycle as the handshake of byte 04.
  - Output is 01..08 with exactly one bubble cycle between 04 and 05.
  - word_count=2.
- Empty FIFO (fifo_empty=1) for 20 cycles:
  - fifo_ren never asserts, m_valid=0, busy=0.
- Reset mid-word, asserted after byte 2 of 0xDEADBEEF:
  - next cycle m_valid=0 and word_count=0.
  - No further bytes from that word.
  - A subsequent word 0xCAFEF00D serializes correctly.

Source files
------------

// File: rtl/fifo_byte_serializer_if.sv
// fifo_byte_serializer_if: FIFO pop port plus byte valid/ready stream seen by the serializer.
interface fifo_byte_serializer_if;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_ren, m_valid, m_data, m_last
  );
  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops 32-bit FIFO words and streams them out as four bytes.
module fifo_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_byte_serializer_if.master bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  logic [1:0]  state;
  logic [31:0] word;
  logic [1:0]  byte_idx;
  logic [1:0]  sel;
  logic        hs;
  logic        last_hs;
  always_comb begin
    hs           = (state == SEND) && bus.m_ready;
    last_hs      = hs && (byte_idx == 2'd3);
    sel          = MSB_FIRST ? ~byte_idx : byte_idx;
    bus.fifo_ren = !rst && !bus.fifo_empty && ((state == IDLE) || last_hs);
    bus.m_valid  = state == SEND;
    bus.m_data   = word[{sel, 3'b000} +: 8];
    bus.m_last   = (state == SEND) && (byte_idx == 2'd3);
    busy         = state != IDLE;
  end
  // The FIFO's registered read data is captured in FETCH, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      byte_idx   <= '0;
      word_count <= '0;
    end else if (state == IDLE) begin
      state <= bus.fifo_empty ? IDLE : FETCH;
    end else if (state == FETCH) begin
      word     <= bus.fifo_rdata;
      byte_idx <= '0;
      state    <= SEND;
    end else if (state == SEND) begin
      if (hs) byte_idx <= byte_idx + 2'd1;
      if (last_hs) begin
        word_count <= word_count + CNT_W'(1);
        state      <= bus.fifo_empty ? IDLE : FETCH;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
